avalon_st_fifo: RTL and testbench

Single-clock, parametrised Avalon-ST FIFO carrying data plus error sideband, with selectable backpressure or drop-on-full behaviour. It is the same-domain counterpart of the clock bridge, used wherever a stream needs elastic buffering deeper than one word. Typical uses are command queues between a CPU-side producer and a peripheral engine, and telemetry streams that must never stall their source.

---
 rtl/avalon_st_pkg.sv | 7 +
 rtl/avalon_st_fifo_mem.sv | 31 +++
 rtl/avalon_st_fifo.sv | 86 ++++++++
 tb/tb_avalon_st_fifo.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/avalon_st_pkg.sv
// avalon_st_pkg: shared widths and helpers for the Avalon-ST FIFO.
package avalon_st_pkg;
    localparam int DROP_COUNT_WIDTH = 16;
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/avalon_st_fifo_mem.sv
// avalon_st_fifo_mem: resettable register array, one write port, asynchronous read port.
module avalon_st_fifo_mem #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we) mem_d[waddr] = wdata;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/avalon_st_fifo.sv
// avalon_st_fifo: single-clock Avalon-ST FIFO with error sideband; AVALON_ST_FIFO_STATS_EN adds level/drop_count/stats_clear.
module avalon_st_fifo import avalon_st_pkg::*; #(
    parameter int DATA_WIDTH   = 8,
    parameter int DEPTH        = 16,
    parameter int DROP_ON_FULL = 0
) (
    input  logic                          clk,
    input  logic                          reset_n,
`ifdef AVALON_ST_FIFO_STATS_EN
    input  logic                          stats_clear,
    output logic [level_width(DEPTH)-1:0] level,
    output logic [DROP_COUNT_WIDTH-1:0]   drop_count,
`endif
    input  logic [DATA_WIDTH-1:0]         sink_data,
    input  logic                          sink_valid,
    input  logic                          sink_error,
    output logic                          sink_ready,
    output logic [DATA_WIDTH-1:0]         source_data,
    output logic                          source_valid,
    output logic                          source_error,
    input  logic                          source_ready
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = level_width(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] count_q, count_d;
    logic          full, push, pop;

    assign full         = count_q == LW'(DEPTH);
    assign source_valid = count_q != '0;
    assign sink_ready   = (DROP_ON_FULL != 0) || !full;

    // In drop mode a word arriving while full survives only if the head leaves in the same cycle.
    always_comb begin
        pop      = source_valid & source_ready;
        push     = (DROP_ON_FULL != 0) ? sink_valid & (!full | pop) : sink_valid & !full;
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + LW'(push) - LW'(pop);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    avalon_st_fifo_mem #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (push),
        .waddr   (wr_ptr_q),
        .wdata   ({sink_error, sink_data}),
        .raddr   (rd_ptr_q),
        .rdata   ({source_error, source_data})
    );

`ifdef AVALON_ST_FIFO_STATS_EN
    logic                        drop;
    logic [DROP_COUNT_WIDTH-1:0] drop_count_q, drop_count_d;

    always_comb begin
        drop         = (DROP_ON_FULL != 0) & sink_valid & !push;
        drop_count_d = stats_clear ? '0 :
                       (drop && drop_count_q != '1) ? drop_count_q + 1'b1 : drop_count_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) drop_count_q <= '0;
        else          drop_count_q <= drop_count_d;
    end

    assign level      = count_q;
    assign drop_count = drop_count_q;
`endif
endmodule

// File: tb/tb_avalon_st_fifo.sv
// tb_avalon_st_fifo: backpressure and drop-on-full FIFOs share stimulus; per-DUT scoreboards check every cycle.
module tb_avalon_st_fifo;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] sink_data;
    logic       sink_valid, sink_error, source_ready, stats_clear;
    logic [7:0] b_data, d_data;
    logic       b_valid, b_err, b_ready, d_valid, d_err, d_ready;
    logic [4:0] b_level, d_level;
    logic [15:0] b_drop, d_drop;

    int errors = 0;
    int checks = 0;

    logic [8:0] bq[$];
    logic [8:0] dq[$];
    int bcnt = 0, dcnt = 0, ddc = 0;

    always #5 clk = ~clk;

    avalon_st_fifo #(.DATA_WIDTH(8), .DEPTH(DEPTH), .DROP_ON_FULL(0)) u_bp (
        .clk (clk), .reset_n (reset_n),
`ifdef AVALON_ST_FIFO_STATS_EN
        .stats_clear (stats_clear), .level (b_level), .drop_count (b_drop),
`endif
        .sink_data (sink_data), .sink_valid (sink_valid), .sink_error (sink_error), .sink_ready (b_ready),
        .source_data (b_data), .source_valid (b_valid), .source_error (b_err), .source_ready (source_ready)
    );

    avalon_st_fifo #(.DATA_WIDTH(8), .DEPTH(DEPTH), .DROP_ON_FULL(1)) u_dr (
        .clk (clk), .reset_n (reset_n),
`ifdef AVALON_ST_FIFO_STATS_EN
        .stats_clear (stats_clear), .level (d_level), .drop_count (d_drop),
`endif
        .sink_data (sink_data), .sink_valid (sink_valid), .sink_error (sink_error), .sink_ready (d_ready),
        .source_data (d_data), .source_valid (d_valid), .source_error (d_err), .source_ready (source_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Backpressure scoreboard: sampled on the falling edge, updated for the following rising edge.
    always @(negedge clk) begin
        logic bpush, bpop;
        if (!reset_n) begin
            bq.delete();
            bcnt = 0;
            chk("b_rst_valid", b_valid, 0);
            chk("b_rst_ready", b_ready, 1);
            chk("b_rst_data", {b_err, b_data}, 0);
        end else begin
            chk("b_valid", b_valid, bcnt != 0);
            chk("b_ready", b_ready, bcnt != DEPTH);
            if (bcnt != 0) chk("b_head", {b_err, b_data}, bq[0]);
`ifdef AVALON_ST_FIFO_STATS_EN
            chk("b_level", b_level, bcnt);
            chk("b_drop", b_drop, 0);
`endif
            bpop  = bcnt != 0 && source_ready;
            bpush = sink_valid && bcnt != DEPTH;
            if (bpop) void'(bq.pop_front());
            if (bpush) bq.push_back({sink_error, sink_data});
            bcnt = bcnt + int'(bpush) - int'(bpop);
        end
    end

    // Drop-on-full scoreboard.
    always @(negedge clk) begin
        logic dpush, dpop;
        if (!reset_n) begin
            dq.delete();
            dcnt = 0;
            ddc  = 0;
            chk("d_rst_valid", d_valid, 0);
            chk("d_rst_data", {d_err, d_data}, 0);
        end else begin
            chk("d_valid", d_valid, dcnt != 0);
            chk("d_ready", d_ready, 1);
            if (dcnt != 0) chk("d_head", {d_err, d_data}, dq[0]);
`ifdef AVALON_ST_FIFO_STATS_EN
            chk("d_level", d_level, dcnt);
            chk("d_drop", d_drop, ddc);
`endif
            dpop  = dcnt != 0 && source_ready;
            dpush = sink_valid && (dcnt != DEPTH || dpop);
            if (stats_clear) ddc = 0;
            else if (sink_valid && !dpush && ddc != 16'hFFFF) ddc++;
            if (dpop) void'(dq.pop_front());
            if (dpush) dq.push_back({sink_error, sink_data});
            dcnt = dcnt + int'(dpush) - int'(dpop);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        reset_n = 1'b0; sink_data = '0; sink_valid = 1'b0; sink_error = 1'b0;
        source_ready = 1'b1; stats_clear = 1'b0;
        repeat (3) tick();
        chk("rst_b_valid", b_valid, 0);
        chk("rst_b_ready", b_ready, 1);
        chk("rst_b_data", {b_err, b_data}, 0);
`ifdef AVALON_ST_FIFO_STATS_EN
        chk("rst_d_level", d_level, 0);
        chk("rst_d_drop", d_drop, 0);
`endif
        reset_n = 1'b1;
        tick();

        // single word: visible one cycle after the push edge, for exactly one cycle
        sink_valid = 1'b1; sink_data = 8'h01;
        chk("single_no_bypass", b_valid, 0);
        tick();
        sink_valid = 1'b0;
        chk("single_valid", b_valid, 1);
        chk("single_data", b_data, 8'h01);
        tick();
        chk("single_gone", b_valid, 0);

        // streaming pass-through, plus an error-flagged word in the middle
        for (int w = 8'h02; w <= 8'h0F; w++) begin
            sink_valid = 1'b1; sink_data = 8'(w);
            tick();
            chk("stream_data", b_data, w);
        end
        for (int w = 8'h54; w <= 8'h56; w++) begin
            sink_data = 8'(w); sink_error = (w == 8'h55);
            tick();
            chk("err_data", b_data, w);
            chk("err_flag", b_err, w == 8'h55);
        end
        sink_valid = 1'b0; sink_error = 1'b0;
        tick();
        chk("stream_drained", b_valid, 0);

        // fill with consumer stalled, then hold 8'h30 at the sink
        source_ready = 1'b0;
        for (int w = 8'h20; w <= 8'h2F; w++) begin
            sink_valid = 1'b1; sink_data = 8'(w);
            tick();
        end
        chk("bp_full_ready", b_ready, 0);
        chk("bp_head", b_data, 8'h20);
        sink_data = 8'h30;
        repeat (3) tick();
        chk("bp_held_ready", b_ready, 0);
        chk("bp_held_head", b_data, 8'h20);
        source_ready = 1'b1;
        tick();
        chk("bp_ready_after_pop", b_ready, 1);
        chk("bp_next_head", b_data, 8'h21);
        tick();
        sink_valid = 1'b0;
        n = 0;
        while ((b_valid || d_valid) && n < 100) begin tick(); n++; end
        chk("bp_drain_bound", n < 100, 1);
`ifdef AVALON_ST_FIFO_STATS_EN
        chk("bp_dr_drops", d_drop, 3);
`endif

        // drop mode: 20 words into a stalled FIFO, then a push coincident with a pop
        stats_clear = 1'b1;
        tick();
        stats_clear = 1'b0;
`ifdef AVALON_ST_FIFO_STATS_EN
        chk("clear_drop", d_drop, 0);
`endif
        source_ready = 1'b0;
        for (int w = 8'h40; w <= 8'h53; w++) begin
            sink_valid = 1'b1; sink_data = 8'(w);
            tick();
        end
        sink_valid = 1'b0;
        chk("drop_head", d_data, 8'h40);
`ifdef AVALON_ST_FIFO_STATS_EN
        chk("drop_count4", d_drop, 4);
        chk("drop_level", d_level, 16);
`endif
        sink_valid = 1'b1; sink_data = 8'h60; source_ready = 1'b1;
        tick();
        sink_valid = 1'b0; source_ready = 1'b0;
        chk("drop_pop_head", d_data, 8'h41);
`ifdef AVALON_ST_FIFO_STATS_EN
        chk("drop_kept", d_drop, 4);
        chk("drop_kept_level", d_level, 16);
`endif
        source_ready = 1'b1;
        n = 0;
        while ((b_valid || d_valid) && n < 100) begin tick(); n++; end
        chk("drop_drain_bound", n < 100, 1);

        // reset with words queued
        source_ready = 1'b0;
        for (int w = 8'h70; w <= 8'h74; w++) begin
            sink_valid = 1'b1; sink_data = 8'(w);
            tick();
        end
        sink_valid = 1'b0;
        chk("pre_rst_valid", b_valid, 1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_b_valid", b_valid, 0);
        chk("mid_rst_d_valid", d_valid, 0);
        chk("mid_rst_data", b_data, 0);
`ifdef AVALON_ST_FIFO_STATS_EN
        chk("mid_rst_level", b_level, 0);
`endif
        repeat (2) tick();
        reset_n = 1'b1;
        source_ready = 1'b1;
        repeat (3) tick();
        chk("post_rst_b_valid", b_valid, 0);
        chk("post_rst_d_valid", d_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
